// File: rtl/vc_test_sink_pkg.sv
// Shared types and constants for the val/rdy test sink.
package vc_test_sink_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sink_state_e;

  localparam int unsigned ErrCntW = 16;
  localparam logic [ErrCntW-1:0] ErrCntMax = '1;

  function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
    return (v == ErrCntMax) ? v : v + ErrCntW'(1);
  endfunction

endpackage

// File: rtl/vc_eq_comparator.sv
// Combinational W-bit equality compare.
module vc_eq_comparator #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/vc_test_sink.sv
// Val/rdy test sink: checks incoming messages against a loaded table of
// expected values under a fixed backpressure pattern and counts mismatches.
module vc_test_sink
  import vc_test_sink_pkg::*;
#(
  parameter int unsigned MSG_SZ       = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [MSG_SZ-1:0]        load_data,
  input  logic [$clog2(DEPTH):0]   num_msgs,
  input  logic                     start,
  input  logic [MSG_SZ-1:0]        in_msg,
  input  logic                     in_val,
  output logic                     in_rdy,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] err_index,
  output logic [ErrCntW-1:0]       num_errors,
  output logic                     done
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CntW   = AddrW + 1;
  localparam int unsigned StallW = (STALL_PERIOD > 0) ? $clog2(STALL_PERIOD + 1) : 1;
  localparam logic [StallW-1:0] StallLast = StallW'(STALL_PERIOD);

  sink_state_e         state_q, state_d;
  logic [CntW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     num_q, num_d;
  logic [StallW-1:0]   stall_q, stall_d;
  logic                err_q, err_d;
  logic [AddrW-1:0]    err_index_q, err_index_d;
  logic [ErrCntW-1:0]  num_errors_q, num_errors_d;

  logic [MSG_SZ-1:0]   mem_q [DEPTH];
  logic [MSG_SZ-1:0]   exp_msg;
  logic                msg_eq;
  logic                stall_hit;
  logic                xfer;

  // Table is not reset; it must survive a mid-run reset for re-checking.
  always_ff @(posedge clk) begin
    if (load_en && (state_q == StIdle)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign exp_msg = mem_q[idx_q[AddrW-1:0]];

  vc_eq_comparator #(
    .W (MSG_SZ)
  ) u_cmp (
    .a  (in_msg),
    .b  (exp_msg),
    .eq (msg_eq)
  );

  assign stall_hit = (STALL_PERIOD != 0) && (stall_q == StallLast);
  assign in_rdy    = (state_q == StRun) && !stall_hit;
  assign xfer      = in_val && in_rdy;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    stall_d      = stall_q;
    err_d        = 1'b0;
    err_index_d  = err_index_q;
    num_errors_d = num_errors_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d        = num_msgs;
          idx_d        = '0;
          stall_d      = '0;
          err_index_d  = '0;
          num_errors_d = '0;
          state_d      = (num_msgs == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        stall_d = (stall_q == StallLast) ? '0 : stall_q + StallW'(1);
        if (xfer) begin
          idx_d = idx_q + CntW'(1);
          if (!msg_eq) begin
            err_d        = 1'b1;
            err_index_d  = idx_q[AddrW-1:0];
            num_errors_d = sat_inc(num_errors_q);
          end
          if (idx_d == num_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      num_q   <= '0;
      stall_q <= '0;
    end else begin
      idx_q   <= idx_d;
      num_q   <= num_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q        <= 1'b0;
      err_index_q  <= '0;
      num_errors_q <= '0;
    end else begin
      err_q        <= err_d;
      err_index_q  <= err_index_d;
      num_errors_q <= num_errors_d;
    end
  end

  assign err        = err_q;
  assign err_index  = err_index_q;
  assign num_errors = num_errors_q;
  assign done       = (state_q == StDone);

endmodule
